// File: rtl/wrp_shff_pkg.sv
// ---------------------------------------------------------------------------
// wrp_shff_pkg
// Shared types and constants for the shuffle-network input-stage scheduler.
//   state_t        : scheduler FSM states
//   ERR_*          : bit positions within err_o
//   DEF_NLANE      : default lane / shuffle-port count
//   DEF_BURST_LEN  : default read beats per burst
// ---------------------------------------------------------------------------
package wrp_shff_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int ERR_UNDERRUN  = 0;
    localparam int ERR_TIMEOUT   = 1;

    localparam int DEF_NLANE     = 16;
    localparam int DEF_BURST_LEN = 16;

endpackage

// File: rtl/wrp_shff_sched_wdog.sv
// ---------------------------------------------------------------------------
// wrp_shff_sched_wdog
// Stall watchdog for the frame scheduler. Counts cycles in which the
// scheduler is stalled in WAIT. It fires once, on the WDOG_CYC-th stalled
// cycle, and then holds until the scheduler leaves WAIT.
// Ports:
//   clk   : clock
//   srst  : synchronous active-high reset
//   run   : stalled-cycle qualifier (WAIT, enabled, not all ready)
//   clr   : scheduler is outside WAIT; counter returns to 0
//   fire  : combinational, high in the cycle the threshold is reached
// ---------------------------------------------------------------------------
module wrp_shff_sched_wdog #(
    parameter  int WDOG_CYC = 1024,
    localparam int CW       = $clog2(WDOG_CYC + 1)
) (
    input  logic clk,
    input  logic srst,
    input  logic run,
    input  logic clr,
    output logic fire
);

    logic [CW-1:0] cnt_q;

    assign fire = run && (cnt_q == CW'(WDOG_CYC - 1));

    // Saturates at WDOG_CYC so fire can only be produced once per stall.
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            cnt_q <= '0;
        end else if (run && (cnt_q != CW'(WDOG_CYC))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/wrp_shff_sched.sv
// ---------------------------------------------------------------------------
// wrp_shff_sched
// Frame scheduler between the per-lane AIE input buffers and the shuffle
// network. Waits for every lane buffer to hold a burst and every shuffle
// port to be ready, then issues a BURST_LEN-beat read burst. Bursts are
// counted into frames of FRAME_BURSTS; frame boundaries are flagged and the
// output bank alternates once per frame. Lane under-run is flagged sticky.
//
// Build option: define WRP_SHFF_SCHED_WDOG_EN to build the stall watchdog
// (timeout_o / err_o[1]). Without it those outputs stay 0.
//
// Ports:
//   clk, srst     : clock, synchronous active-high reset
//   en_i          : run enable, acted on only at frame boundaries
//   lane_rdy_i    : per-lane burst-available flags
//   dn_rdy_i      : per-port shuffle-network ready
//   start_o       : pulse on the first beat of each burst
//   rd_en_o       : buffer read enable, BURST_LEN cycles per burst
//   sof_o / eof_o : first beat of frame / last beat of frame
//   bank_o        : output bank, toggles the cycle after eof_o
//   busy_o        : FSM not IDLE
//   burst_cnt_o   : burst index within the frame
//   err_o         : sticky errors, [0] under-run, [1] stall timeout
//   timeout_o     : watchdog fire pulse
// All outputs are registered.
// ---------------------------------------------------------------------------
module wrp_shff_sched
    import wrp_shff_pkg::*;
#(
    parameter  int NLANE        = DEF_NLANE,
    parameter  int BURST_LEN    = DEF_BURST_LEN,
    parameter  int FRAME_BURSTS = 4096,
    parameter  int WDOG_CYC     = 1024,
    localparam int BCW          = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en_i,
    input  logic [NLANE-1:0] lane_rdy_i,
    input  logic [NLANE-1:0] dn_rdy_i,
    output logic             start_o,
    output logic             rd_en_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic             bank_o,
    output logic             busy_o,
    output logic [BCW-1:0]   burst_cnt_o,
    output logic [1:0]       err_o,
    output logic             timeout_o
);

    localparam int BEAT_W = $clog2(BURST_LEN);

    state_t            state_q, state_d;
    logic              all_rdy_q;
    logic              gap_q;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BCW-1:0]    bcnt_d;
    logic              last_beat;
    logic              go;
    logic              underrun;
    logic              wdog_fire;

    assign last_beat = (state_q == READ) && (beat_q == BEAT_W'(BURST_LEN - 1));
    assign go        = (state_q == WAIT) && (state_d == READ);
    // The first two beats are exempt: the buffer flags lag the reads.
    assign underrun  = (state_q == READ) && (beat_q >= BEAT_W'(2)) && !(&lane_rdy_i);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en_i) state_d = WAIT;
            WAIT: begin
                if ((burst_cnt_o == '0) && !en_i) begin
                    state_d = IDLE;
                end else if (all_rdy_q && !gap_q) begin
                    // gap_q: all_rdy_q still reflects flags sampled during
                    // GAP, before the buffers refreshed; wait one more sample.
                    state_d = READ;
                end
            end
            READ: if (last_beat) state_d = GAP;
            GAP:  state_d = WAIT;
            default: state_d = IDLE;
        endcase

        beat_d = '0;
        if ((state_q == READ) && !last_beat) beat_d = beat_q + 1'b1;

        bcnt_d = burst_cnt_o;
        if (last_beat) begin
            bcnt_d = (burst_cnt_o == BCW'(FRAME_BURSTS - 1)) ? '0 : burst_cnt_o + 1'b1;
        end
    end

`ifdef WRP_SHFF_SCHED_WDOG_EN
    wrp_shff_sched_wdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_wdog (
        .clk  (clk),
        .srst (srst),
        .run  ((state_q == WAIT) && en_i && !all_rdy_q),
        .clr  (state_q != WAIT),
        .fire (wdog_fire)
    );
`else
    localparam int unused_wdog_cyc = WDOG_CYC;
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= IDLE;
            all_rdy_q   <= 1'b0;
            gap_q       <= 1'b0;
            beat_q      <= '0;
            burst_cnt_o <= '0;
            start_o     <= 1'b0;
            rd_en_o     <= 1'b0;
            sof_o       <= 1'b0;
            eof_o       <= 1'b0;
            bank_o      <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= '0;
            timeout_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            all_rdy_q   <= (&lane_rdy_i) && (&dn_rdy_i);
            gap_q       <= (state_q == GAP);
            beat_q      <= beat_d;
            burst_cnt_o <= bcnt_d;
            start_o     <= go;
            rd_en_o     <= (state_d == READ);
            sof_o       <= go && (burst_cnt_o == '0);
            // burst_cnt only advances after the final beat, so it is still
            // the index of the burst whose last beat is being issued.
            eof_o       <= (state_d == READ) && (beat_d == BEAT_W'(BURST_LEN - 1)) &&
                           (burst_cnt_o == BCW'(FRAME_BURSTS - 1));
            bank_o      <= bank_o ^ eof_o;
            busy_o      <= (state_d != IDLE);
            err_o[ERR_UNDERRUN] <= err_o[ERR_UNDERRUN] | underrun;
            err_o[ERR_TIMEOUT]  <= err_o[ERR_TIMEOUT]  | wdog_fire;
            timeout_o   <= wdog_fire;
        end
    end

endmodule

// File: doc/wrp_shff_sched.md
# wrp_shff_sched

Frame scheduler for the shuffle-network input stage. It sits between the 16 per-lane AIE input buffers and the shuffle network. It waits until every lane buffer holds a full burst and every shuffle-network port is ready, then issues fixed-length read bursts. It also counts bursts into frames, marks frame boundaries, alternates the output bank, and flags lane under-run.

## Interface
Parameters:
- NLANE, 16, number of lane buffers and shuffle ports
- BURST_LEN, 16, read beats per burst (power of 2, ≥4)
- FRAME_BURSTS, 4096, bursts per FFT frame (power of 2)
- WDOG_CYC, 1024, stall-timeout threshold in cycles (watchdog build only)

Ports:
- clk  in  1  clock; all logic rising-edge
- srst  in  1  reset, synchronous, active-high
- en_i  in  1  run enable; sampled only at frame boundaries
- lane_rdy_i  in  NLANE  per-lane "burst available" flag from the input buffers
- dn_rdy_i  in  NLANE  per-port ready from the shuffle network
- start_o  out  1  one-cycle pulse at the first beat of each burst
- rd_en_o  out  1  buffer read enable, high for exactly BURST_LEN cycles per burst
- sof_o  out  1  coincident with start_o on the first burst of a frame
- eof_o  out  1  high on the last beat of the last burst of a frame
- bank_o  out  1  output bank select; toggles the cycle after eof_o
- busy_o  out  1  high whenever the FSM is not IDLE
- burst_cnt_o  out  log2(FRAME_BURSTS)  index of the current burst within the frame
- err_o  out  2  sticky: [0] lane under-run, [1] stall timeout
- timeout_o  out  1  one-cycle pulse when the watchdog fires

## Operation
- all_rdy_q is a registered copy of (&lane_rdy_i & &dn_rdy_i), so it lags the inputs by 1 cycle.
- FSM states: IDLE, WAIT, READ, GAP.
  - IDLE: when en_i=1 → WAIT. burst_cnt is 0.
  - WAIT: when all_rdy_q=1 → READ, and start_o and rd_en_o assert in the first READ cycle. At a frame boundary (burst_cnt=0) with en_i=0 → IDLE. en_i is ignored everywhere else.
  - READ: the beat counter runs 0..BURST_LEN-1. On the final beat → GAP, and burst_cnt increments, wrapping to 0 after FRAME_BURSTS-1.
  - GAP: lasts exactly 1 cycle so the buffers can refresh lane_rdy_i; then → WAIT.
- sof_o = start_o when burst_cnt=0. eof_o is asserted on the final beat when burst_cnt=FRAME_BURSTS-1.
- bank_o flips on the cycle after eof_o.
- Under-run: if any lane_rdy_i bit is 0 while in READ, excluding the first 2 beats (buffer flag latency), err_o[0] sets. The burst still completes so the lanes stay aligned.
- srst mid-burst: all state clears next cycle. The burst is abandoned; the buffers are reset by the same srst.
- Reset values: start_o, rd_en_o, sof_o, eof_o, bank_o, busy_o, timeout_o = 0; burst_cnt_o = 0; err_o = 0; FSM = IDLE.

## Timing
- All outputs are registered.
- Latency from inputs all ready to start_o = 2 cycles: 1 cycle for the all_rdy_q register plus 1 cycle for the WAIT→READ transition.
- Minimum burst period = BURST_LEN + 3 cycles (READ + GAP + WAIT + sample).
- rd_en_o never has a gap within a burst; no cycle has start_o without rd_en_o.
- If all_rdy_q is high again in WAIT, back-to-back bursts are spaced by exactly the minimum period.

## Configuration
- WRP_SHFF_SCHED_WDOG_EN defined:
  - A counter runs while in WAIT with en_i=1 and all_rdy_q=0; it clears on leaving WAIT.
  - When it reaches WDOG_CYC, timeout_o pulses once and err_o[1] sets.
  - The counter holds until WAIT is exited; the FSM behaviour is unchanged.
- Not defined: timeout_o and err_o[1] are tied to 0, and no counter logic is built.

## Structure
- Package wrp_shff_pkg holds:
  - the FSM state enum (IDLE/WAIT/READ/GAP);
  - the error-bit index localparams (ERR_UNDERRUN=0, ERR_TIMEOUT=1);
  - the default NLANE and BURST_LEN.
- One sub-module, wrp_shff_sched_wdog, holds the watchdog counter. It is instantiated only under WRP_SHFF_SCHED_WDOG_EN.

## Test plan
- Basic burst: reset, en_i=1, all ready at cycle 10 → start_o at cycle 12; rd_en_o high for 16 cycles; sof_o=1; burst_cnt_o=1 after the burst.
- Partial ready: lane 7 low → no start_o. Lane 7 goes high at cycle T → start_o at T+2.
- Frame wrap: FRAME_BURSTS=4, ready held → eof_o on the last beat of the 4th burst; bank_o 0→1 on the next cycle; the next start_o carries sof_o.
- Under-run: drop lane_rdy_i[3] on beat 5 → err_o=01 (sticky); rd_en_o still lasts 16 cycles.
- en_i drop: deassert en_i in burst 2 of 4 → remaining bursts complete, then IDLE with busy_o=0.
- Watchdog (macro on, WDOG_CYC=32): lane 0 held low → timeout_o pulses at the 32nd WAIT cycle and err_o[1]=1. Reset mid-READ → all outputs return to 0 on the next cycle.
